// File: rtl/data_memory_be_pkg.sv
// dmem_pkg: shared encodings and helpers for the byte-enabled data memory.
//   SZ_*        request size encodings (req_size)
//   state_e     controller state: INIT clear sweep, RUN normal service
//   dmem_misaligned / dmem_byte_en  alignment check and lane write enables
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_e;

    function automatic logic dmem_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = lane[0];
            SZ_WORD: mis = (lane != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

    // Byte enables for a store; a misaligned or reserved request enables nothing.
    function automatic logic [3:0] dmem_byte_en(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        be = 4'b0000;
        if (!dmem_misaligned(size, lane)) begin
            case (size)
                SZ_BYTE: be = 4'b0001 << lane;
                SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
                SZ_WORD: be = 4'b1111;
                default: be = 4'b0000;
            endcase
        end
        return be;
    endfunction

endpackage

// File: rtl/data_memory_be_load_align.sv
// dmem_load_align: picks the addressed byte/half out of a memory word and
// sign- or zero-extends it to 32 bits.
//   word        raw 32-bit word read from the array
//   size        SZ_BYTE / SZ_HALF / SZ_WORD (reserved yields 0)
//   lane        byte address bits [1:0]
//   is_unsigned 1 = zero-extend, 0 = sign-extend
//   data        extended result
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: data = is_unsigned ? {24'h0, b} : {{24{b[7]}}, b};
            SZ_HALF: data = is_unsigned ? {16'h0, h} : {{16{h[15]}}, h};
            SZ_WORD: data = word;
            default: data = 32'h0;
        endcase
    end

endmodule

// File: rtl/data_memory_be.sv
// data_memory_be: word-organised data RAM with byte/half/word access.
//   clk, reset (async, active-low)
//   req_valid/req_ready handshake; req_write, req_size, req_unsigned,
//   req_addr (byte address), req_wdata (right-aligned store data)
//   rsp_valid/rsp_rdata: load response READ_LATENCY cycles after acceptance
//   rsp_misaligned: error flag (store: 1 cycle after accept, load: response slot)
//   init_done: clear sweep complete, requests accepted from then on
module data_memory_be
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS    = 512,
    parameter int ADDR_BITS      = 9,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_misaligned,
    output logic        init_done
);

    state_e                 state;
    logic [ADDR_BITS-1:0]   clear_cnt;
    logic [31:0]            mem [DEPTH_WORDS];

    logic                   accept;
    logic [ADDR_BITS-1:0]   widx;
    logic                   req_mis;
    logic [3:0]             be;
    logic [31:0]            wdata_rep;
    logic                   unused_addr_hi;

    // Stage 1: RAM output register plus the request attributes needed to
    // align it; these line up with ram_q.
    logic [31:0]            ram_q;
    logic                   s1_ld, s1_mis, s1_st_mis, s1_uns;
    logic [1:0]             s1_size, s1_lane;
    logic [31:0]            s1_aligned, s1_data;

    logic                   ld_vld, ld_mis;
    logic [31:0]            ld_data;

    // Gating with reset keeps ready low while reset is held even when the
    // sweep is disabled and the state already sits in RUN.
    assign req_ready = (state == RUN) && reset;
    assign init_done = (state == RUN);

    assign accept         = req_valid && req_ready;
    assign widx           = req_addr[ADDR_BITS+1:2];
    assign req_mis        = dmem_misaligned(req_size, req_addr[1:0]);
    assign be             = dmem_byte_en(req_size, req_addr[1:0]);
    assign unused_addr_hi = ^req_addr[31:ADDR_BITS+2];

    // Replicate store data across lanes so each byte enable picks its own copy.
    always_comb begin
        case (req_size)
            SZ_BYTE: wdata_rep = {4{req_wdata[7:0]}};
            SZ_HALF: wdata_rep = {2{req_wdata[15:0]}};
            default: wdata_rep = req_wdata;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= (CLEAR_ON_RESET != 0) ? INIT : RUN;
            clear_cnt <= '0;
        end else if (state == INIT) begin
            clear_cnt <= clear_cnt + 1'b1;
            if (clear_cnt == ADDR_BITS'(DEPTH_WORDS - 1))
                state <= RUN;
        end
    end

    // Array has no reset so it maps onto block RAM; the INIT sweep clears it.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[clear_cnt] <= '0;
        end else if (accept && req_write) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[widx][8*i +: 8] <= wdata_rep[8*i +: 8];
        end
        if (accept && !req_write)
            ram_q <= mem[widx];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_ld     <= 1'b0;
            s1_mis    <= 1'b0;
            s1_st_mis <= 1'b0;
            s1_uns    <= 1'b0;
            s1_size   <= SZ_BYTE;
            s1_lane   <= 2'b00;
        end else begin
            s1_ld     <= accept && !req_write;
            s1_mis    <= accept && req_mis;
            s1_st_mis <= accept && req_write && req_mis;
            if (accept) begin
                s1_uns  <= req_unsigned;
                s1_size <= req_size;
                s1_lane <= req_addr[1:0];
            end
        end
    end

    dmem_load_align u_align (
        .word        (ram_q),
        .size        (s1_size),
        .lane        (s1_lane),
        .is_unsigned (s1_uns),
        .data        (s1_aligned)
    );

    // Data is forced to zero outside a good load so nothing leaks between slots.
    assign s1_data = (s1_ld && !s1_mis) ? s1_aligned : 32'h0;

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic        r2_vld, r2_mis;
            logic [31:0] r2_data;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r2_vld  <= 1'b0;
                    r2_mis  <= 1'b0;
                    r2_data <= 32'h0;
                end else begin
                    r2_vld  <= s1_ld;
                    r2_mis  <= s1_ld && s1_mis;
                    r2_data <= s1_data;
                end
            end
            assign ld_vld  = r2_vld;
            assign ld_mis  = r2_mis;
            assign ld_data = r2_data;
        end else begin : g_lat1
            assign ld_vld  = s1_ld;
            assign ld_mis  = s1_ld && s1_mis;
            assign ld_data = s1_data;
        end
    endgenerate

    assign rsp_valid      = ld_vld;
    assign rsp_rdata      = ld_data;
    assign rsp_misaligned = ld_mis | s1_st_mis;

endmodule

// File: tb/tb_data_memory_be.sv
module tb_data_memory_be;

    typedef struct {
        int          due;
        bit          ld;
        logic [31:0] data;
        bit          mis;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;

    logic        a_ready, a_valid, a_mis, a_done;
    logic [31:0] a_rdata;
    logic        b_ready, b_valid, b_mis, b_done;
    logic [31:0] b_rdata;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    ev_t q0[$];
    ev_t q1[$];
    logic [31:0] mdl [2][512];
    int dep [2] = '{16, 512};
    int lat [2] = '{1, 2};

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // A: small array, single-cycle reads. B: full size, two-cycle reads.
    data_memory_be #(.DEPTH_WORDS(16), .ADDR_BITS(4), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) u_a (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(a_ready),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(a_valid),
        .rsp_rdata(a_rdata), .rsp_misaligned(a_mis), .init_done(a_done));

    data_memory_be #(.DEPTH_WORDS(512), .ADDR_BITS(9), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) u_b (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(b_ready),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(b_valid),
        .rsp_rdata(b_rdata), .rsp_misaligned(b_mis), .init_done(b_done));

    function automatic bit tb_mis(input logic [1:0] sz, input logic [1:0] lo);
        return (sz == 2'b11) || (sz == 2'b01 && lo[0]) || (sz == 2'b10 && lo != 2'b00);
    endfunction

    function automatic logic [31:0] mdl_load(input int id, input logic [31:0] addr,
                                             input logic [1:0] sz, input logic uns);
        logic [31:0] w;
        logic [7:0]  b8;
        logic [15:0] h16;
        w = mdl[id][int'(addr >> 2) % dep[id]];
        case (sz)
            2'b00: begin
                b8 = 8'(w >> (int'(addr[1:0]) * 8));
                return uns ? {24'h0, b8} : {{24{b8[7]}}, b8};
            end
            2'b01: begin
                h16 = 16'(w >> (int'(addr[1]) * 16));
                return uns ? {16'h0, h16} : {{16{h16[15]}}, h16};
            end
            default: return w;
        endcase
    endfunction

    task automatic mdl_store(input int id, input logic [31:0] addr,
                             input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] mask;
        int sh, wi;
        mask = (sz == 2'b00) ? 32'hFF : (sz == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
        sh = int'(addr[1:0]) * 8;
        wi = int'(addr >> 2) % dep[id];
        mdl[id][wi] = (mdl[id][wi] & ~(mask << sh)) | ((wd & mask) << sh);
    endtask

    task automatic mdl_clear();
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 512; j++) mdl[i][j] = 32'h0;
    endtask

    task automatic push(input int id, input ev_t e);
        if (id == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    // One request held for one cycle. use_exp supplies a hand-derived load value.
    task automatic issue(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic use_exp, input logic [31:0] exp);
        ev_t e;
        int c;
        bit m;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz;
        req_unsigned = uns; req_addr = addr; req_wdata = wd;
        tests++;
        assert ((a_ready && b_ready) === 1'b1)
        else begin fails++; $error("FAIL req_ready: got a=%b b=%b, want 1", a_ready, b_ready); end
        c = cyc;
        m = tb_mis(sz, addr[1:0]);
        for (int id = 0; id < 2; id++) begin
            if (w) begin
                if (m) begin
                    e.due = c + 1; e.ld = 0; e.data = 32'h0; e.mis = 1;
                    push(id, e);
                end else mdl_store(id, addr, sz, wd);
            end else begin
                e.due = c + lat[id]; e.ld = 1; e.mis = m;
                e.data = m ? 32'h0 : (use_exp ? exp : mdl_load(id, addr, sz, uns));
                push(id, e);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
    endtask

    task automatic check_rsp(input int id, input logic v, input logic [31:0] d, input logic m);
        logic ev, em;
        logic [31:0] ed;
        ev_t e;
        ev = 0; em = 0; ed = 32'h0;
        forever begin
            if (id == 0) begin
                if (q0.size() == 0 || q0[0].due > cyc) break;
                e = q0.pop_front();
            end else begin
                if (q1.size() == 0 || q1[0].due > cyc) break;
                e = q1.pop_front();
            end
            if (e.due < cyc) begin
                tests++; fails++;
                $error("FAIL dut%0d missed_slot: due cycle %0d, now %0d", id, e.due, cyc);
            end else begin
                if (e.ld) begin ev = 1; ed = e.data; end
                em = em | e.mis;
            end
        end
        tests++;
        assert (v === ev) else begin fails++; $error("FAIL dut%0d rsp_valid cyc %0d: got %b want %b", id, cyc, v, ev); end
        tests++;
        assert (d === ed) else begin fails++; $error("FAIL dut%0d rsp_rdata cyc %0d: got %h want %h", id, cyc, d, ed); end
        tests++;
        assert (m === em) else begin fails++; $error("FAIL dut%0d rsp_misaligned cyc %0d: got %b want %b", id, cyc, m, em); end
    endtask

    always @(negedge clk) begin
        check_rsp(0, a_valid, a_rdata, a_mis);
        check_rsp(1, b_valid, b_rdata, b_mis);
    end

    // Release reset and measure how many edges each instance keeps ready low.
    task automatic release_and_count();
        int ta, tb_;
        ta = 0; tb_ = 0;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 2000; k++) begin
            @(posedge clk); #1;
            if (a_ready && ta == 0) ta = k;
            if (b_ready && tb_ == 0) tb_ = k;
            if (ta != 0 && tb_ != 0) break;
        end
        tests++;
        assert (ta === 16) else begin fails++; $error("FAIL sweep_a: ready after %0d edges, want 16", ta); end
        tests++;
        assert (tb_ === 512) else begin fails++; $error("FAIL sweep_b: ready after %0d edges, want 512", tb_); end
        tests++;
        assert ((a_done && b_done) === 1'b1) else begin fails++; $error("FAIL init_done: got a=%b b=%b want 1", a_done, b_done); end
    endtask

    task automatic check_reset_outputs(input string tag);
        tests++;
        assert ({a_ready, a_valid, a_mis, a_done, a_rdata} === 36'h0)
        else begin fails++; $error("FAIL %s_a: got rdy=%b v=%b m=%b d=%b rd=%h want all 0", tag, a_ready, a_valid, a_mis, a_done, a_rdata); end
        tests++;
        assert ({b_ready, b_valid, b_mis, b_done, b_rdata} === 36'h0)
        else begin fails++; $error("FAIL %s_b: got rdy=%b v=%b m=%b d=%b rd=%h want all 0", tag, b_ready, b_valid, b_mis, b_done, b_rdata); end
    endtask

    initial begin
        mdl_clear();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        release_and_count();

        // Cleared contents, then extension cases.
        issue(0, 2'b10, 0, 32'h3C, 0, 1, 32'h0000_0000);
        issue(1, 2'b10, 0, 32'h10, 32'h80FF_7F01, 0, 0);
        issue(0, 2'b00, 0, 32'h13, 0, 1, 32'hFFFF_FF80);
        issue(0, 2'b00, 1, 32'h12, 0, 1, 32'h0000_00FF);
        issue(0, 2'b01, 0, 32'h10, 0, 1, 32'h0000_7F01);
        // Byte merge into an existing word.
        issue(1, 2'b10, 0, 32'h20, 32'h1122_3344, 0, 0);
        issue(1, 2'b00, 0, 32'h21, 32'h0000_00AB, 0, 0);
        issue(0, 2'b10, 0, 32'h20, 0, 1, 32'h1122_AB44);
        idle(3);
        // Misaligned store must not touch the word; misaligned/reserved loads flag.
        issue(1, 2'b01, 0, 32'h31, 32'h0000_BEEF, 0, 0);
        idle(2);
        issue(0, 2'b10, 0, 32'h30, 0, 1, 32'h0000_0000);
        issue(0, 2'b10, 0, 32'h32, 0, 1, 32'h0000_0000);
        issue(0, 2'b11, 0, 32'h00, 0, 1, 32'h0000_0000);
        idle(2);
        issue(1, 2'b11, 0, 32'h04, 32'h1234_5678, 0, 0);
        idle(3);
        // Store-then-load back to back, and address wrap.
        issue(1, 2'b10, 0, 32'h40, 32'hDEAD_BEEF, 0, 0);
        issue(0, 2'b10, 0, 32'h40, 0, 1, 32'hDEAD_BEEF);
        issue(0, 2'b10, 0, 32'h840, 0, 1, 32'hDEAD_BEEF);
        idle(3);

        // Mixed random traffic against the reference model.
        for (int i = 0; i < 60; i++)
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  32'($urandom_range(0, 255)), $urandom, 0, 0);
        idle(4);
        tests++;
        assert ((q0.size() + q1.size()) === 0)
        else begin fails++; $error("FAIL drain: got %0d pending responses, want 0", q0.size() + q1.size()); end

        // Reset in the middle of the sweep restarts it from word 0.
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b0;
        mdl_clear();
        #1;
        check_reset_outputs("midsweep");
        release_and_count();
        issue(0, 2'b10, 0, 32'h40, 0, 1, 32'h0000_0000);
        issue(0, 2'b10, 0, 32'h10, 0, 1, 32'h0000_0000);
        issue(0, 2'b10, 0, 32'h3C, 0, 1, 32'h0000_0000);
        idle(4);
        tests++;
        assert ((q0.size() + q1.size()) === 0)
        else begin fails++; $error("FAIL final_drain: got %0d pending responses, want 0", q0.size() + q1.size()); end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
